// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler: accepts ASCII characters over valid/ready, looks up
// each character's Morse pattern and times marks/gaps in prescaled units
// to drive an active-low LED bank.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   char_valid  source presents a character
//   char_data   ASCII character, sampled on handshake
//   char_ready  scheduler can accept a character
//   abort       level-sensitive abort of the current character
//   busy        high while a character (or word gap) is being sent
//   sym_err     one-cycle pulse: accepted character has no Morse code
//   leds        active-low LED drive, all 0 = mark, all 1 = dark
//
// Build option: define DIGITS_EN to add '0'-'9' to the code table.
module morse_tx_scheduler #(
  parameter int unsigned CLK_DIV = 13_500_000,
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned LED_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  input  logic             abort,
  output logic             busy,
  output logic             sym_err,
  output logic [LED_W-1:0] leds
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_EL_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [2:0]         r_units, w_units_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [2:0]         r_len;
  logic [4:0]         r_bits;
  logic [LED_W-1:0]   r_leds;
  logic               r_busy;
  logic               r_err, w_err_nxt;

  logic [7:0]         w_lc;
  logic [2:0]         w_len;
  logic [4:0]         w_bits;
  logic               w_is_space;
  logic               w_xfer;
  logic               w_tick;
  logic               w_dash;
  logic [2:0]         w_need;
  logic               w_unit_done;

  // Code table: length 1..5, element 0 in bit 0, 1 = dash. Length 0 = no code.
  always_comb begin
    w_lc = ((char_data >= 8'h41) && (char_data <= 8'h5A)) ? (char_data | 8'h20) : char_data;
    {w_len, w_bits} = 8'd0;
    case (w_lc)
      "a": {w_len, w_bits} = {3'd2, 5'b00010};
      "b": {w_len, w_bits} = {3'd4, 5'b00001};
      "c": {w_len, w_bits} = {3'd4, 5'b00101};
      "d": {w_len, w_bits} = {3'd3, 5'b00001};
      "e": {w_len, w_bits} = {3'd1, 5'b00000};
      "f": {w_len, w_bits} = {3'd4, 5'b00100};
      "g": {w_len, w_bits} = {3'd3, 5'b00011};
      "h": {w_len, w_bits} = {3'd4, 5'b00000};
      "i": {w_len, w_bits} = {3'd2, 5'b00000};
      "j": {w_len, w_bits} = {3'd4, 5'b01110};
      "k": {w_len, w_bits} = {3'd3, 5'b00101};
      "l": {w_len, w_bits} = {3'd4, 5'b00010};
      "m": {w_len, w_bits} = {3'd2, 5'b00011};
      "n": {w_len, w_bits} = {3'd2, 5'b00001};
      "o": {w_len, w_bits} = {3'd3, 5'b00111};
      "p": {w_len, w_bits} = {3'd4, 5'b00110};
      "q": {w_len, w_bits} = {3'd4, 5'b01011};
      "r": {w_len, w_bits} = {3'd3, 5'b00010};
      "s": {w_len, w_bits} = {3'd3, 5'b00000};
      "t": {w_len, w_bits} = {3'd1, 5'b00001};
      "u": {w_len, w_bits} = {3'd3, 5'b00100};
      "v": {w_len, w_bits} = {3'd4, 5'b01000};
      "w": {w_len, w_bits} = {3'd3, 5'b00110};
      "x": {w_len, w_bits} = {3'd4, 5'b01001};
      "y": {w_len, w_bits} = {3'd4, 5'b01101};
      "z": {w_len, w_bits} = {3'd4, 5'b00011};
`ifdef DIGITS_EN
      "0": {w_len, w_bits} = {3'd5, 5'b11111};
      "1": {w_len, w_bits} = {3'd5, 5'b11110};
      "2": {w_len, w_bits} = {3'd5, 5'b11100};
      "3": {w_len, w_bits} = {3'd5, 5'b11000};
      "4": {w_len, w_bits} = {3'd5, 5'b10000};
      "5": {w_len, w_bits} = {3'd5, 5'b00000};
      "6": {w_len, w_bits} = {3'd5, 5'b00001};
      "7": {w_len, w_bits} = {3'd5, 5'b00011};
      "8": {w_len, w_bits} = {3'd5, 5'b00111};
      "9": {w_len, w_bits} = {3'd5, 5'b01111};
`else
`endif
      default: {w_len, w_bits} = 8'd0;
    endcase
  end

  assign w_is_space = (char_data == 8'h20);

  // The cycle after an unsupported character also holds off the source.
  assign char_ready = (r_state == S_IDLE) && !abort && !r_err && !rst;
  assign w_xfer     = char_valid && char_ready;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_dash = |(r_bits & (5'd1 << r_idx));

  // Units each state lasts.
  always_comb begin
    case (r_state)
      S_MARK:     w_need = w_dash ? 3'd3 : 3'd1;
      S_CHAR_GAP: w_need = 3'd3;
      S_WORD_GAP: w_need = 3'd4;
      default:    w_need = 3'd1;
    endcase
  end

  assign w_unit_done = w_tick && (r_units == (w_need - 3'd1));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          if (w_len != 3'd0) begin
            w_state_nxt = S_MARK;
            w_idx_nxt   = 3'd0;
          end else if (w_is_space) begin
            w_state_nxt = S_WORD_GAP;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (w_unit_done) begin
          w_state_nxt = (r_idx == (r_len - 3'd1)) ? S_CHAR_GAP : S_EL_GAP;
        end
      end
      S_EL_GAP: begin
        if (w_unit_done) begin
          w_state_nxt = S_MARK;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (w_unit_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_state_nxt = S_IDLE;

    // Prescaler and unit counter restart on every state entry and rest in IDLE.
    if ((w_state_nxt != r_state) || (r_state == S_IDLE)) begin
      w_div_nxt   = '0;
      w_units_nxt = 3'd0;
    end else if (w_tick) begin
      w_div_nxt   = '0;
      w_units_nxt = r_units + 3'd1;
    end else begin
      w_div_nxt   = r_div + DIV_W'(1);
      w_units_nxt = r_units;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_units <= 3'd0;
      r_idx   <= 3'd0;
      r_len   <= 3'd0;
      r_bits  <= 5'd0;
      r_leds  <= '1;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_units <= w_units_nxt;
      r_idx   <= w_idx_nxt;
      r_leds  <= (w_state_nxt == S_MARK) ? '0 : '1;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_err   <= w_err_nxt;
      if (w_xfer) begin
        r_len  <= w_len;
        r_bits <= w_bits;
      end
    end
  end

  assign leds    = r_leds;
  assign busy    = r_busy;
  assign sym_err = r_err;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
module tb_morse_tx_scheduler;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DIV_W   = 24;
  localparam int unsigned LED_W   = 6;
  localparam int          LIMIT   = 400;

  logic             clk = 1'b0;
  logic             rst;
  logic             char_valid;
  logic [7:0]       char_data;
  logic             char_ready;
  logic             abort;
  logic             busy;
  logic             sym_err;
  logic [LED_W-1:0] leds;

  int n_vec = 0;
  int n_err = 0;

  morse_tx_scheduler #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W), .LED_W(LED_W)) dut (
    .clk(clk), .rst(rst), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .abort(abort), .busy(busy), .sym_err(sym_err),
    .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lit;
    bit bsy;
    bit err;
    bit rdy;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] ch;
    int         busy_cyc;
    int         marks;
    int         errs;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Morse as dot/dash text; " " = word gap, "?" = no code.
  function automatic string morse_of(input logic [7:0] c);
    logic [7:0] l;
    l = ((c >= "A") && (c <= "Z")) ? c + 8'd32 : c;
    case (l)
      "a": return ".-";    "b": return "-...";  "c": return "-.-.";
      "d": return "-..";   "e": return ".";     "f": return "..-.";
      "g": return "--.";   "h": return "....";  "i": return "..";
      "j": return ".---";  "k": return "-.-";   "l": return ".-..";
      "m": return "--";    "n": return "-.";    "o": return "---";
      "p": return ".--.";  "q": return "--.-";  "r": return ".-.";
      "s": return "...";   "t": return "-";     "u": return "..-";
      "v": return "...-";  "w": return ".--";   "x": return "-..-";
      "y": return "-.--";  "z": return "--..";
`ifdef DIGITS_EN
      "0": return "-----"; "1": return ".----"; "2": return "..---";
      "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---..";
      "9": return "----.";
`endif
      " ": return " ";
      default: return "?";
    endcase
  endfunction

  task automatic push(input bit lit, input bit bsy, input bit err, input bit rdy, input int n);
    exp_t e;
    e.lit = lit; e.bsy = bsy; e.err = err; e.rdy = rdy;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Expected per-cycle outputs from the cycle after the handshake until ready returns.
  task automatic build_trace(input logic [7:0] c);
    string s;
    logic [7:0] el;
    exp_q.delete();
    s = morse_of(c);
    if (s == "?") begin
      push(0, 0, 1, 0, 1);
    end else if (s == " ") begin
      push(0, 1, 0, 0, 4 * CLK_DIV);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        el = s[i];
        push(1, 1, 0, 0, ((el == "-") ? 3 : 1) * CLK_DIV);
        push(0, 1, 0, 0, ((i == s.len() - 1) ? 3 : 1) * CLK_DIV);
      end
    end
    push(0, 0, 0, 1, 1);
  endtask

  // Watch the DUT from the current negedge until it is idle and ready again.
  task automatic observe(input bit chk, input string nm, output int nbusy,
                         output int nmarks, output int nerr, output int ndark, output int ncyc);
    int  k;
    bit  done;
    bit  prev_lit;
    bit  lit;
    logic [LED_W-1:0] el;
    k = 0; done = 0; prev_lit = 0;
    nbusy = 0; nmarks = 0; nerr = 0; ndark = 0;
    while (!done) begin
      lit = (leds == '0);
      if (busy) nbusy++;
      if (busy && (leds == '1)) ndark++;
      if (lit && !prev_lit) nmarks++;
      if (sym_err) nerr++;
      prev_lit = lit;
      if (chk) begin
        if (k < exp_q.size()) begin
          el = exp_q[k].lit ? '0 : '1;
          check({nm, "_cycle"}, 64'({leds, busy, sym_err, char_ready}),
                64'({el, exp_q[k].bsy, exp_q[k].err, exp_q[k].rdy}));
        end else begin
          check({nm, "_overrun"}, 64'(k), 64'(exp_q.size() - 1));
        end
      end
      k++;
      if (!busy && char_ready) begin
        done = 1;
      end else if (k >= LIMIT) begin
        check({nm, "_timeout"}, 64'(k), 64'(0));
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    ncyc = k;
    if (chk) check({nm, "_len"}, 64'(k), 64'(exp_q.size()));
  endtask

  task automatic run_char(input logic [7:0] c, input string nm, output int nbusy,
                          output int nmarks, output int nerr, output int ndark, output int ncyc);
    @(negedge clk);
    check({nm, "_ready_pre"}, 64'(char_ready), 64'(1));
    char_valid = 1'b1;
    char_data  = c;
    build_trace(c);
    @(negedge clk);
    char_valid = 1'b0;
    char_data  = 8'h00;
    observe(1, nm, nbusy, nmarks, nerr, ndark, ncyc);
  endtask

  vec_t  vecs[10];
  int    nb, nm, ne, nd, nc;
  int    dark_sum;
  string pool;
  logic [7:0] rc;

  initial begin
    vecs[0] = '{"e", 16, 1, 0};
    vecs[1] = '{"A", 32, 2, 0};
    vecs[2] = '{"t", 24, 1, 0};
    vecs[3] = '{"m", 40, 2, 0};
    vecs[4] = '{"s", 32, 3, 0};
    vecs[5] = '{"q", 64, 4, 0};
    vecs[6] = '{"Z", 56, 4, 0};
    vecs[7] = '{" ", 16, 0, 0};
    vecs[8] = '{"#",  0, 0, 1};
`ifdef DIGITS_EN
    vecs[9] = '{"5", 48, 5, 0};
`else
    vecs[9] = '{"5",  0, 0, 1};
`endif

    rst = 1'b1; char_valid = 1'b0; char_data = 8'h00; abort = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_leds",    64'(leds),       64'({LED_W{1'b1}}));
    check("rst_busy",    64'(busy),       64'(0));
    check("rst_sym_err", 64'(sym_err),    64'(0));
    check("rst_ready",   64'(char_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(char_ready), 64'(1));

    // Table of characters with hand-computed totals.
    for (int i = 0; i < 10; i++) begin
      run_char(vecs[i].ch, "tbl", nb, nm, ne, nd, nc);
      check("tbl_busy_cycles", 64'(nb), 64'(vecs[i].busy_cyc));
      check("tbl_marks",       64'(nm), 64'(vecs[i].marks));
      check("tbl_sym_err",     64'(ne), 64'(vecs[i].errs));
    end

    // Unsupported code: ready returns two cycles after the handshake.
    run_char("#", "err", nb, nm, ne, nd, nc);
    check("err_ready_after", 64'(nc), 64'(2));

    // 'A' with 't' held valid behind it; the held data change must be ignored.
    @(negedge clk);
    char_valid = 1'b1; char_data = "A";
    @(negedge clk);
    char_data = "t";
    build_trace("A");
    observe(1, "A_hold", nb, nm, ne, nd, nc);
    check("t_accept_cycle", 64'(nc), 64'(33));
    @(negedge clk);
    char_valid = 1'b0; char_data = 8'h00;
    build_trace("t");
    observe(1, "t_held", nb, nm, ne, nd, nc);
    check("t_busy_cycles", 64'(nb), 64'(24));

    // 'e',' ','e': 3+4 dark units between marks while busy.
    run_char("e", "gap_e1", nb, nm, ne, nd, nc);
    dark_sum = nd;
    run_char(" ", "gap_sp", nb, nm, ne, nd, nc);
    dark_sum += nd;
    check("word_gap_dark", 64'(dark_sum), 64'(7 * CLK_DIV));
    run_char("e", "gap_e2", nb, nm, ne, nd, nc);
    check("gap_e2_marks", 64'(nm), 64'(1));

    // Abort six cycles into the first dash of 'm'.
    @(negedge clk);
    char_valid = 1'b1; char_data = "m";
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_pre_lit", 64'(leds), 64'(0));
    abort = 1'b1;
    @(negedge clk);
    check("abort_leds",  64'(leds),       64'({LED_W{1'b1}}));
    check("abort_busy",  64'(busy),       64'(0));
    check("abort_ready", 64'(char_ready), 64'(0));
    // Abort held in IDLE beats a simultaneous valid.
    char_valid = 1'b1; char_data = "e";
    @(negedge clk);
    check("abort_idle_busy", 64'({busy, sym_err, leds}), 64'({2'b00, {LED_W{1'b1}}}));
    abort = 1'b0; char_valid = 1'b0;
    #1;
    check("abort_release_ready", 64'(char_ready), 64'(1));
    run_char("e", "post_abort", nb, nm, ne, nd, nc);

    // Reset six cycles into the first dash of 'm'.
    @(negedge clk);
    char_valid = 1'b1; char_data = "m";
    @(negedge clk);
    char_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_leds",  64'(leds),       64'({LED_W{1'b1}}));
    check("midrst_busy",  64'(busy),       64'(0));
    check("midrst_ready", 64'(char_ready), 64'(0));
    rst = 1'b0;
    run_char("e", "post_rst", nb, nm, ne, nd, nc);
    run_char("o", "post_rst2", nb, nm, ne, nd, nc);

    // Random characters against the reference trace.
    pool = "etaoinshrdlucmfwypvbgkjqxzETAONSZ 0123456789#?!@,.";
    for (int i = 0; i < 30; i++) begin
      rc = pool[$urandom_range(0, pool.len() - 1)];
      run_char(rc, "rand", nb, nm, ne, nd, nc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
